// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and types for the UART command parser.
// ASCII codes, FSM state and command-type encodings.
package cmd_pkg;

    localparam logic [7:0] CH_L    = 8'h6c;
    localparam logic [7:0] CH_L_UC = 8'h4c;
    localparam logic [7:0] CH_A    = 8'h61;
    localparam logic [7:0] CH_A_UC = 8'h41;
    localparam logic [7:0] CH_AT   = 8'h40;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_CR   = 8'h0d;

    localparam logic [3:0] MAX_TENS = 4'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIGITS  = 2'd1,
        WAIT_CR = 2'd2
    } state_e;

    typedef enum logic {
        TIME  = 1'b0,
        ALARM = 1'b1
    } cmd_e;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / command-out bundle of the UART command parser.
// master = byte source and consumer of strobes, slave = parser.
interface uart_cmd_parser_if;

    logic [7:0]  rx_data;
    logic        rx_data_rdy;
    logic        ld_time;
    logic        ld_alarm;
    logic [15:0] bcd_val;
    logic        alarm_en;
    logic        cmd_err;
    logic        busy;

    modport master (
        output rx_data,
        output rx_data_rdy,
        input  ld_time,
        input  ld_alarm,
        input  bcd_val,
        input  alarm_en,
        input  cmd_err,
        input  busy
    );

    modport slave (
        input  rx_data,
        input  rx_data_rdy,
        output ld_time,
        output ld_alarm,
        output bcd_val,
        output alarm_en,
        output cmd_err,
        output busy
    );

endinterface

// File: rtl/uart_cmd_parser_ascii_bcd_check.sv
// Classifies one ASCII byte as a BCD digit for a given MM:SS position.
// Tens positions (index 0 and 2) accept 0-5, ones positions 0-9.
module ascii_bcd_check
    import cmd_pkg::*;
(
    input  logic [7:0] byte_i,
    input  logic [1:0] idx_i,
    output logic       is_digit_o,
    output logic       in_range_o,
    output logic [3:0] nibble_o
);

    logic [7:0] diff;

    // Bytes below '0' wrap to large values, so one compare covers both ends.
    assign diff       = byte_i - CH_0;
    assign is_digit_o = (diff <= 8'd9);
    assign nibble_o   = diff[3:0];

    always_comb begin
        in_range_o = is_digit_o;
        unique case (idx_i)
            2'd0, 2'd2: in_range_o = is_digit_o && (nibble_o <= MAX_TENS);
            default:    in_range_o = is_digit_o;
        endcase
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: l/a + 4 BCD digits + CR loads, @ toggles alarm.
// Bad bytes abort with cmd_err; the committed value is never touched.
module uart_cmd_parser
    import cmd_pkg::*;
#(
    parameter logic [7:0] CR_CHAR = CH_CR
) (
    input logic             clk12m,
    input logic             rst,
    uart_cmd_parser_if.slave bus
);

    state_e      state_q, state_d;
    cmd_e        cmd_q, cmd_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] stage_q, stage_d;
    logic [15:0] bcd_q, bcd_d;
    logic        alarm_en_q, alarm_en_d;
    logic        ld_time_q, ld_time_d;
    logic        ld_alarm_q, ld_alarm_d;
    logic        cmd_err_q, cmd_err_d;

    logic        is_digit;
    logic        in_range;
    logic [3:0]  nibble;

    ascii_bcd_check u_check (
        .byte_i     (bus.rx_data),
        .idx_i      (idx_q),
        .is_digit_o (is_digit),
        .in_range_o (in_range),
        .nibble_o   (nibble)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        stage_d    = stage_q;
        bcd_d      = bcd_q;
        alarm_en_d = alarm_en_q;
        ld_time_d  = 1'b0;
        ld_alarm_d = 1'b0;
        cmd_err_d  = 1'b0;

        if (bus.rx_data_rdy) begin
            unique case (state_q)
                IDLE: begin
                    unique case (1'b1)
                        (bus.rx_data == CH_L) || (bus.rx_data == CH_L_UC): begin
                            cmd_d   = TIME;
                            idx_d   = 2'd0;
                            state_d = DIGITS;
                        end
                        (bus.rx_data == CH_A) || (bus.rx_data == CH_A_UC): begin
                            cmd_d   = ALARM;
                            idx_d   = 2'd0;
                            state_d = DIGITS;
                        end
                        (bus.rx_data == CH_AT): begin
                            alarm_en_d = ~alarm_en_q;
                        end
                        default: ;
                    endcase
                end
                DIGITS: begin
                    if (in_range) begin
                        // Shift in MSB-first; four accepts fill all nibbles.
                        stage_d = {stage_q[11:0], nibble};
                        idx_d   = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = WAIT_CR;
                        end
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                WAIT_CR: begin
                    state_d = IDLE;
                    if (bus.rx_data == CR_CHAR) begin
                        bcd_d      = stage_q;
                        ld_time_d  = (cmd_q == TIME);
                        ld_alarm_d = (cmd_q == ALARM);
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk12m or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= TIME;
            idx_q      <= 2'd0;
            stage_q    <= 16'h0000;
            bcd_q      <= 16'h0000;
            alarm_en_q <= 1'b0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
            bcd_q      <= bcd_d;
            alarm_en_q <= alarm_en_d;
            ld_time_q  <= ld_time_d;
            ld_alarm_q <= ld_alarm_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign bus.ld_time  = ld_time_q;
    assign bus.ld_alarm = ld_alarm_q;
    assign bus.cmd_err  = cmd_err_q;
    assign bus.bcd_val  = bcd_q;
    assign bus.alarm_en = alarm_en_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
